// File: rtl/sequence_generator.sv
`default_nettype none
// ============================================================================
// Module   : sequence_generator
// Purpose  : Serial pattern transmitter. Shifts a latched pattern out
//            MSB-first, repeated N times with optional idle gaps in between.
// Revision : 1.0 - initial release
// ============================================================================
module sequence_generator #(
   parameter int   PAT_W    = 3,
   parameter int   CNT_W    = 8,
   parameter int   GAP_W    = 4,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic [GAP_W-1:0] gap,
   input  logic             abort,
   output logic             dataout,
   output logic             data_valid,
   output logic             frame_start,
   output logic             done,
   output logic             busy
);

   localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [GAP_W-1:0]   gcnt_q, gcnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               dout_q, dout_d;
   logic               dv_q, dv_d;
   logic               fs_q, fs_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic [IDX_W-1:0]   idx_dec;

   assign idx_dec = idx_q - 1'b1;

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      rem_d   = rem_q;
      gap_d   = gap_q;
      gcnt_d  = gcnt_q;
      idx_d   = idx_q;
      dout_d  = IDLE_BIT;
      dv_d    = 1'b0;
      fs_d    = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_valid) begin
               pat_d = pattern;
               rem_d = repeat_cnt;
               gap_d = gap;
               idx_d = IDX_MSB;
               if (repeat_cnt == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_SHIFT;
                  dout_d  = pattern[PAT_W-1];
                  dv_d    = 1'b1;
                  fs_d    = 1'b1;
               end
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (idx_q != '0) begin
               idx_d  = idx_dec;
               dout_d = pat_q[idx_dec];
               dv_d   = 1'b1;
            end else if (rem_q == CNT_W'(1)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               rem_d = rem_q - 1'b1;
               if (gap_q == '0) begin
                  // back-to-back repetition: next frame starts immediately
                  idx_d  = IDX_MSB;
                  dout_d = pat_q[PAT_W-1];
                  dv_d   = 1'b1;
                  fs_d   = 1'b1;
               end else begin
                  state_d = ST_GAP;
                  gcnt_d  = gap_q;
               end
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (gcnt_q <= GAP_W'(1)) begin
               state_d = ST_SHIFT;
               idx_d   = IDX_MSB;
               dout_d  = pat_q[PAT_W-1];
               dv_d    = 1'b1;
               fs_d    = 1'b1;
            end else begin
               gcnt_d = gcnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         pat_q   <= '0;
         rem_q   <= '0;
         gap_q   <= '0;
         gcnt_q  <= '0;
         idx_q   <= '0;
         dout_q  <= IDLE_BIT;
         dv_q    <= 1'b0;
         fs_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         rem_q   <= rem_d;
         gap_q   <= gap_d;
         gcnt_q  <= gcnt_d;
         idx_q   <= idx_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
         fs_q    <= fs_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign start_ready = (state_q == ST_IDLE);
   assign dataout     = dout_q;
   assign data_valid  = dv_q;
   assign frame_start = fs_q;
   assign done        = done_q;
   assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sequence_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sequence_generator
// Purpose  : Scoreboard bench for sequence_generator with a cycle-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sequence_generator;

   localparam int   PAT_W    = 3;
   localparam int   CNT_W    = 8;
   localparam int   GAP_W    = 4;
   localparam logic IDLE_BIT = 1'b0;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start_valid;
   logic             start_ready;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] repeat_cnt;
   logic [GAP_W-1:0] gap;
   logic             abort;
   logic             dataout;
   logic             data_valid;
   logic             frame_start;
   logic             done;
   logic             busy;

   int errors = 0;
   int checks = 0;

   // One entry per busy cycle: {dataout, data_valid, frame_start, done}
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   sequence_generator #(
      .PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W), .IDLE_BIT(IDLE_BIT)
   ) dut (
      .clk(clk), .reset(rst_n), .start_valid(start_valid), .start_ready(start_ready),
      .pattern(pattern), .repeat_cnt(repeat_cnt), .gap(gap), .abort(abort),
      .dataout(dataout), .data_valid(data_valid), .frame_start(frame_start),
      .done(done), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expand one accepted request into its full cycle-by-cycle output list.
   task automatic push_txn(input logic [PAT_W-1:0] p, input int n, input int g);
      for (int r = 0; r < n; r++) begin
         for (int b = PAT_W - 1; b >= 0; b--)
            exp_q.push_back({p[b], 1'b1, (b == PAT_W - 1), 1'b0});
         if (r < n - 1)
            for (int k = 0; k < g; k++) exp_q.push_back({IDLE_BIT, 3'b000});
      end
      exp_q.push_back({IDLE_BIT, 3'b001});
   endtask

   always @(negedge clk) begin
      logic [3:0] e;
      if (busy) begin
         if (exp_q.size() == 0) begin
            check("unexpected_busy", 32'(busy), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("busy_cycle_outputs", 32'({dataout, data_valid, frame_start, done}), 32'(e));
         end
      end else begin
         check("idle_outputs", 32'({dataout, data_valid, frame_start, done}), 32'({IDLE_BIT, 3'b000}));
      end
   end

   task automatic cycle(input logic sv, input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] rc,
                        input logic [GAP_W-1:0] g, input logic ab);
      logic idle;
      logic flush;
      @(posedge clk);
      #2;
      idle = (exp_q.size() == 0);
      check("start_ready", 32'(start_ready), 32'(idle));
      start_valid = sv;
      pattern     = p;
      repeat_cnt  = rc;
      gap         = g;
      abort       = ab;
      if (sv && idle) push_txn(p, int'(rc), int'(g));
      flush = ab && !idle;
      @(negedge clk);
      #1;
      if (flush) exp_q.delete();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, PAT_W'($urandom), CNT_W'($urandom), GAP_W'($urandom), 1'b0);
   endtask

   task automatic drain();
      int budget = 2000;
      while (exp_q.size() != 0 && budget > 0) begin
         idle_cycles(1);
         budget--;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_values();
      check("rst_dataout", 32'(dataout), 32'(IDLE_BIT));
      check("rst_data_valid", 32'(data_valid), 32'd0);
      check("rst_frame_start", 32'(frame_start), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_start_ready", 32'(start_ready), 32'd1);
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #2;
      rst_n       = 1'b0;
      start_valid = 1'b0;
      abort       = 1'b0;
      #1;
      check_reset_values();
      exp_q.delete();
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      start_valid = 1'b0;
      pattern     = '0;
      repeat_cnt  = '0;
      gap         = '0;
      abort       = 1'b0;
      #1;
      check_reset_values();
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;

      // back-to-back repetitions
      cycle(1'b1, 3'b101, 8'd2, 4'd0, 1'b0);
      drain();
      idle_cycles(2);
      // gapped repetitions
      cycle(1'b1, 3'b101, 8'd3, 4'd2, 1'b0);
      drain();
      idle_cycles(1);
      // zero repeat count
      cycle(1'b1, 3'b110, 8'd0, 4'd3, 1'b0);
      drain();
      idle_cycles(1);
      // abort on the second bit of repetition 2, then an immediate new request
      cycle(1'b1, 3'b011, 8'd4, 4'd1, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 3'b000, 8'd0, 4'd0, 1'b0);
      cycle(1'b0, 3'b000, 8'd0, 4'd0, 1'b1);
      cycle(1'b1, 3'b100, 8'd1, 4'd0, 1'b0);
      drain();
      idle_cycles(1);
      // abort and start together in idle: request wins
      cycle(1'b1, 3'b111, 8'd2, 4'd1, 1'b1);
      drain();
      // hold start_valid with a changing pattern
      for (int i = 0; i < 30; i++) cycle(1'b1, PAT_W'($urandom), 8'd2, 4'd1, 1'b0);
      start_valid = 1'b0;
      drain();
      idle_cycles(1);
      // mid-run reset, then a normal request
      cycle(1'b1, 3'b101, 8'd5, 4'd2, 1'b0);
      idle_cycles(4);
      reset_pulse();
      cycle(1'b1, 3'b010, 8'd2, 4'd0, 1'b0);
      drain();
      idle_cycles(1);
      // maximum repeat count
      cycle(1'b1, 3'b100, 8'hFF, 4'd0, 1'b0);
      drain();
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [GAP_W-1:0] g;
         g = ($urandom % 8 == 0) ? GAP_W'(15) : GAP_W'($urandom_range(0, 3));
         cycle(($urandom % 4) == 0, PAT_W'($urandom), CNT_W'($urandom_range(0, 4)), g,
               ($urandom % 30) == 0);
      end
      abort = 1'b0;
      drain();
      idle_cycles(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
